// File: rtl/gyro_spi_seq.sv
// Sequencer for the SPI_mnrch link to the iNEMO gyro: three-write init, then a yaw-rate pair read per data-ready.
// Defining SEQ_BOOT_WAIT_EN adds a 2^TMR_W-cycle boot wait before the first init write.
module gyro_spi_seq #(
    parameter int unsigned TMR_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] resp,
    output logic        snd,
    output logic [15:0] cmd,
    output logic        init_done,
    output logic [15:0] yaw,
    output logic        vld
);
    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        INIT1 = 3'd1,
        INIT2 = 3'd2,
        INIT3 = 3'd3,
        IDLE  = 3'd4,
        RD_YL = 3'd5,
        RD_YH = 3'd6,
        HOLD  = 3'd7
    } state_t;

    localparam logic [15:0] CMD_INIT1 = 16'h0D02;
    localparam logic [15:0] CMD_INIT2 = 16'h1160;
    localparam logic [15:0] CMD_INIT3 = 16'h1440;
    localparam logic [15:0] CMD_RD_YL = 16'hA600;
    localparam logic [15:0] CMD_RD_YH = 16'hA700;

    state_t      state_q, state_d;
    logic        int_meta_q, int_s_q;
    logic        snd_q, snd_d;
    logic [15:0] cmd_q, cmd_d;
    logic        init_done_q, init_done_d;
    logic [15:0] yaw_q, yaw_d;
    logic        vld_q, vld_d;
    logic [7:0]  ylo_q, ylo_d;
    logic [1:0]  hold_q, hold_d;
    logic        issue_now_s;
    logic        wait_done_s;
    logic [7:0]  resp_hi_unused_s;

    assign resp_hi_unused_s = resp[15:8];

`ifdef SEQ_BOOT_WAIT_EN
    localparam state_t RST_STATE = BOOT;
    logic [TMR_W-1:0] boot_cnt_q, boot_cnt_d;
    assign issue_now_s = 1'b0;
`else
    localparam state_t RST_STATE = INIT1;
    localparam int unsigned TMR_W_UNUSED = TMR_W;
    logic start_q;
    // Without a boot wait the reset state itself must issue INIT1 on the first edge.
    assign issue_now_s = start_q;
`endif

    // A command state only listens to done after its ISSUE cycle; done may still be high from the previous frame.
    assign wait_done_s = done & ~snd_q & ~issue_now_s;

    // Next-state, command issue and sample assembly.
    always_comb begin
        state_d     = state_q;
        snd_d       = 1'b0;
        cmd_d       = cmd_q;
        init_done_d = init_done_q;
        yaw_d       = yaw_q;
        vld_d       = 1'b0;
        ylo_d       = ylo_q;
        hold_d      = hold_q;
`ifdef SEQ_BOOT_WAIT_EN
        boot_cnt_d  = boot_cnt_q;
`endif
        case (state_q)
            BOOT: begin
`ifdef SEQ_BOOT_WAIT_EN
                boot_cnt_d = boot_cnt_q + TMR_W'(1);
                if (&boot_cnt_q) begin
                    state_d = INIT1;
                    snd_d   = 1'b1;
                    cmd_d   = CMD_INIT1;
                end else begin
                    state_d = BOOT;
                end
`else
                state_d = INIT1;
                snd_d   = 1'b1;
                cmd_d   = CMD_INIT1;
`endif
            end
            INIT1: begin
                if (issue_now_s) begin
                    snd_d = 1'b1;
                    cmd_d = CMD_INIT1;
                end else if (wait_done_s) begin
                    state_d = INIT2;
                    snd_d   = 1'b1;
                    cmd_d   = CMD_INIT2;
                end else begin
                    state_d = INIT1;
                end
            end
            INIT2: begin
                if (wait_done_s) begin
                    state_d = INIT3;
                    snd_d   = 1'b1;
                    cmd_d   = CMD_INIT3;
                end else begin
                    state_d = INIT2;
                end
            end
            INIT3: begin
                if (wait_done_s) begin
                    state_d     = IDLE;
                    init_done_d = 1'b1;
                end else begin
                    state_d = INIT3;
                end
            end
            IDLE: begin
                if (int_s_q) begin
                    state_d = RD_YL;
                    snd_d   = 1'b1;
                    cmd_d   = CMD_RD_YL;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_YL: begin
                if (wait_done_s) begin
                    ylo_d   = resp[7:0];
                    state_d = RD_YH;
                    snd_d   = 1'b1;
                    cmd_d   = CMD_RD_YH;
                end else begin
                    state_d = RD_YL;
                end
            end
            RD_YH: begin
                if (wait_done_s) begin
                    yaw_d   = {resp[7:0], ylo_q};
                    vld_d   = 1'b1;
                    hold_d  = 2'd0;
                    state_d = HOLD;
                end else begin
                    state_d = RD_YH;
                end
            end
            HOLD: begin
                // Three cycles let a cleared INT drain through the synchronizer before IDLE looks again.
                if (hold_q == 2'd2) begin
                    hold_d  = 2'd0;
                    state_d = IDLE;
                end else begin
                    hold_d  = hold_q + 2'd1;
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = RST_STATE;
            end
        endcase
    end

    // State, synchronizer and output registers; rst clears them immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RST_STATE;
            int_meta_q  <= 1'b0;
            int_s_q     <= 1'b0;
            snd_q       <= 1'b0;
            cmd_q       <= 16'h0000;
            init_done_q <= 1'b0;
            yaw_q       <= 16'h0000;
            vld_q       <= 1'b0;
            ylo_q       <= 8'h00;
            hold_q      <= 2'd0;
`ifdef SEQ_BOOT_WAIT_EN
            boot_cnt_q  <= '0;
`else
            start_q     <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            int_meta_q  <= INT;
            int_s_q     <= int_meta_q;
            snd_q       <= snd_d;
            cmd_q       <= cmd_d;
            init_done_q <= init_done_d;
            yaw_q       <= yaw_d;
            vld_q       <= vld_d;
            ylo_q       <= ylo_d;
            hold_q      <= hold_d;
`ifdef SEQ_BOOT_WAIT_EN
            boot_cnt_q  <= boot_cnt_d;
`else
            start_q     <= 1'b0;
`endif
        end
    end

    assign snd       = snd_q;
    assign cmd       = cmd_q;
    assign init_done = init_done_q;
    assign yaw       = yaw_q;
    assign vld       = vld_q;
endmodule

// File: tb/tb_gyro_spi_seq.sv
// Bench for gyro_spi_seq: SPI_mnrch + sensor register model, command-order scoreboard and read vector table.
module tb_gyro_spi_seq;
    localparam int TMR_W = 4;
`ifdef SEQ_BOOT_WAIT_EN
    localparam int BOOT_LAT = 16;
`else
    localparam int BOOT_LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        int_in;
    logic        done;
    logic [15:0] resp;
    logic        snd;
    logic [15:0] cmd;
    logic        init_done;
    logic [15:0] yaw;
    logic        vld;

    gyro_spi_seq #(.TMR_W(TMR_W)) dut (
        .clk(clk), .rst(rst), .INT(int_in), .done(done), .resp(resp),
        .snd(snd), .cmd(cmd), .init_done(init_done), .yaw(yaw), .vld(vld)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cmd[$];
    logic [7:0]  reg_l = 8'h00;
    logic [7:0]  reg_h = 8'h00;
    logic [15:0] cur = 16'h0000;
    int          busy = 0;
    int          mcyc = 0;
    int          a7_done_at = 0;
    int          ovl_cnt = 0;
    int          snd_cnt = 0;
    int          vld_cnt = 0;

    typedef struct {
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic        b2b;
        logic [15:0] exp;
    } vec_t;
    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sensor register map as seen through a read command.
    function automatic logic [7:0] sensor_reg(input logic [15:0] c);
        case (c[15:8])
            8'hA6:   return reg_l;
            8'hA7:   return reg_h;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [15:0] ref_yaw(input logic [7:0] hi, input logic [7:0] lo);
        int v;
        v = int'(hi) * 256 + int'(lo);
        return v[15:0];
    endfunction

    // SPI_mnrch model: random 2..6 cycle frames, done held until the next snd.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            done <= 1'b1;
            busy <= 0;
            resp <= 16'h0000;
        end else begin
            mcyc <= mcyc + 1;
            if (snd) begin
                if (busy != 0 || done !== 1'b1) ovl_cnt <= ovl_cnt + 1;
                cur  <= cmd;
                busy <= $urandom_range(2, 6);
                done <= 1'b0;
            end else if (busy != 0) begin
                busy <= busy - 1;
                if (busy == 1) begin
                    done <= 1'b1;
                    resp <= {8'($urandom), sensor_reg(cur)};
                    if (cur == 16'hA700) a7_done_at <= mcyc + 1;
                end
            end
        end
    end

    // Every issued command must be the next one the scoreboard expects.
    always @(negedge clk) begin
        if (!rst && snd) begin
            snd_cnt++;
            if (exp_cmd.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_snd: got cmd %h with no command expected", cmd);
            end else begin
                chk("cmd_order", cmd, exp_cmd.pop_front());
            end
        end
        if (!rst && vld) vld_cnt++;
    end

    task automatic wait_snd(input int limit, output int n);
        n = -1;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (snd) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic wait_init(input int limit, output logic ok);
        ok = 1'b0;
        for (int k = 0; k < limit && !ok; k++) begin
            @(negedge clk);
            ok = init_done;
        end
    endtask

    task automatic wait_vld(input int limit, output logic ok);
        ok = 1'b0;
        for (int k = 0; k < limit && !ok; k++) begin
            @(negedge clk);
            ok = vld;
        end
    endtask

    task automatic push_init();
        exp_cmd.push_back(16'h0D02);
        exp_cmd.push_back(16'h1160);
        exp_cmd.push_back(16'h1440);
    endtask

    initial begin
        int          n;
        logic        got;
        int          s0;
        int          v0;

        vt[0] = '{8'h34, 8'h12, 1'b0, 16'h1234};
        vt[1] = '{8'h00, 8'hFF, 1'b0, 16'hFF00};
        vt[2] = '{8'hFF, 8'h7F, 1'b1, 16'h7FFF};
        vt[3] = '{8'h01, 8'h80, 1'b1, 16'h8001};
        for (int i = 4; i < 8; i++) begin
            vt[i].lo  = 8'($urandom);
            vt[i].hi  = 8'($urandom);
            vt[i].b2b = 1'(i % 2);
            vt[i].exp = ref_yaw(vt[i].hi, vt[i].lo);
        end

        rst    = 1'b1;
        int_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_snd", snd, 0);
        chk("rst_cmd", cmd, 16'h0000);
        chk("rst_init_done", init_done, 0);
        chk("rst_yaw", yaw, 16'h0000);
        chk("rst_vld", vld, 0);

        push_init();
        rst = 1'b0;
        wait_snd(BOOT_LAT + 8, n);
        chk("first_snd_latency", n, BOOT_LAT);
        chk("first_cmd", cmd, 16'h0D02);
        wait_init(200, got);
        chk("init_done", got, 1);
        chk("init_cmds_left", exp_cmd.size(), 0);

        for (int i = 0; i < 8; i++) begin
            if (!vt[i].b2b) repeat (20) @(negedge clk);
            reg_l = vt[i].lo;
            reg_h = vt[i].hi;
            exp_cmd.push_back(16'hA600);
            exp_cmd.push_back(16'hA700);
            int_in = 1'b1;
            // From IDLE: 2 sync edges + decision edge; back-to-back: INT rises two cycles into HOLD, same count.
            wait_snd(10, n);
            chk("int_to_snd", n, 3);
            wait_vld(80, got);
            chk("vld_seen", got, 1);
            chk("yaw", yaw, vt[i].exp);
            chk("done_to_vld", mcyc - a7_done_at, 1);
            int_in = 1'b0;
            @(negedge clk);
            chk("vld_one_cycle", vld, 0);
        end

        s0 = snd_cnt;
        v0 = vld_cnt;
        repeat (1000) @(negedge clk);
        chk("quiet_snd", snd_cnt, s0);
        chk("quiet_vld", vld_cnt, v0);
        chk("quiet_yaw", yaw, vt[7].exp);

        reg_l = 8'h5A;
        reg_h = 8'hC3;
        exp_cmd.push_back(16'hA600);
        exp_cmd.push_back(16'hA700);
        int_in = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (snd && cmd == 16'hA700) got = 1'b1;
        end
        chk("reach_rd_yh", got, 1);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        int_in = 1'b0;
        #1;
        chk("midrst_snd", snd, 0);
        chk("midrst_vld", vld, 0);
        chk("midrst_yaw", yaw, 16'h0000);
        chk("midrst_init_done", init_done, 0);
        chk("midrst_cmd", cmd, 16'h0000);
        repeat (2) @(negedge clk);
        chk("midrst_pending", exp_cmd.size(), 0);

        push_init();
        rst = 1'b0;
        wait_snd(BOOT_LAT + 8, n);
        chk("reinit_snd_latency", n, BOOT_LAT);
        wait_init(200, got);
        chk("reinit_done", got, 1);
        chk("reinit_yaw_zero", yaw, 16'h0000);

        reg_l = 8'($urandom);
        reg_h = 8'($urandom);
        exp_cmd.push_back(16'hA600);
        exp_cmd.push_back(16'hA700);
        int_in = 1'b1;
        wait_vld(120, got);
        chk("post_rst_vld", got, 1);
        chk("post_rst_yaw", yaw, ref_yaw(reg_h, reg_l));
        int_in = 1'b0;
        repeat (10) @(negedge clk);

        chk("overlapping_snd", ovl_cnt, 0);
        chk("cmds_left", exp_cmd.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
